// File: rtl/q2_pkg.sv
// Shared types and field helpers for the q2 word-addressed accumulator core.
package q2_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_FETCH = 2'd1,
    ST_IND   = 2'd2,
    ST_EXEC  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_NOR = 3'd0,
    OP_ADD = 3'd1,
    OP_LDA = 3'd2,
    OP_STA = 3'd3,
    OP_SHR = 3'd4,
    OP_JC  = 3'd5,
    OP_JMP = 3'd6,
    OP_JZ  = 3'd7
  } op_t;

  // Instruction layout: [W-1:W-3] op, [W-4] deref, [W-5] page, [W-6:0] offset.
  function automatic int op_lsb(input int w);
    return w - 3;
  endfunction

  function automatic int deref_pos(input int w);
    return w - 4;
  endfunction

  function automatic int page_pos(input int w);
    return w - 5;
  endfunction

  function automatic logic is_mem_op(input op_t op);
    return op <= OP_STA;
  endfunction

endpackage

// File: rtl/q2_alu_w.sv
// Combinational word ALU: computes the new accumulator and flag for NOR/ADD/LDA/SHR.
module q2_alu_w
  import q2_pkg::*;
#(
  parameter int W = 12
) (
  input  op_t          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] m,
  input  logic         f,
  output logic [W-1:0] result,
  output logic         f_next
);

  logic [W:0] sum;

  assign sum = {1'b0, a} + {1'b0, m};

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    result = a;
    f_next = f;
    case (op)
      OP_NOR: result = ~(a | m);
      OP_ADD: {f_next, result} = sum;
      OP_LDA: result = m;
      OP_SHR: begin
        result = {f, a[W-1:1]};
        f_next = a[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/q2_core_w.sv
// q2 core: STOP/FETCH/IND/EXEC sequencer with a single held-until-ack memory port.
module q2_core_w
  import q2_pkg::*;
#(
  parameter int W         = 12,
  parameter int PAGE_BITS = W - 5
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start,
  input  logic         stop,
  input  logic         dep,
  input  logic [W-1:0] sw,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_ack,
  output logic         run,
  output logic         halt,
  output logic [W-1:0] a_out,
  output logic [W-1:0] p_out,
  output logic         f_out
);

  localparam int OP_LSB = op_lsb(W);
  localparam int DEREF  = deref_pos(W);
  localparam int PAGE   = page_pos(W);

  state_t       state, state_nx;
  logic [W-1:0] a, p, p_inst, ea, dep_data;
  logic [3:0]   ir;  // op + deref; address fields are folded into ea at fetch
  logic         f, stop_seen, dep_pend;
  op_t          op;
  logic [W-1:0] ea_fetch, alu_res;
  logic         alu_f, retire, halt_set;

  assign op = op_t'(ir[3:1]);

  assign ea_fetch = mem_rdata[PAGE]
                  ? {p[W-1:PAGE_BITS], mem_rdata[PAGE_BITS-1:0]}
                  : {{(W-PAGE_BITS){1'b0}}, mem_rdata[PAGE_BITS-1:0]};

  assign retire   = (state == ST_EXEC) && (!is_mem_op(op) || mem_ack);
  assign halt_set = retire && (op == OP_JMP) && !ir[0] && (ea == p_inst);

  q2_alu_w #(.W(W)) u_alu (
    .op     (op),
    .a      (a),
    .m      (mem_rdata),
    .f      (f),
    .result (alu_res),
    .f_next (alu_f)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ST_STOP;
    else       state <= state_nx;
  end

  // Memory port is decoded from registered state, so it drops the instant nrst asserts.
  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = p;
    mem_wdata = a;
    case (state)
      ST_STOP: begin
        if (dep_pend) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_wdata = dep_data;
        end else if (start && !dep) begin
          state_nx = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) state_nx = mem_rdata[DEREF] ? ST_IND : ST_EXEC;
      end
      ST_IND: begin
        mem_req  = 1'b1;
        mem_addr = ea;
        if (mem_ack) state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_mem_op(op)) begin
          mem_req  = 1'b1;
          mem_we   = (op == OP_STA);
          mem_addr = ea;
        end
        if (retire) begin
          state_nx = (stop_seen || stop || halt || halt_set) ? ST_STOP : ST_FETCH;
        end
      end
      default: state_nx = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      a         <= '0;
      p         <= '0;
      f         <= 1'b0;
      ir        <= '0;
      p_inst    <= '0;
      ea        <= '0;
      dep_data  <= '0;
      dep_pend  <= 1'b0;
      stop_seen <= 1'b0;
      halt      <= 1'b0;
    end else begin
      case (state)
        ST_STOP: begin
          stop_seen <= 1'b0;
          if (dep_pend) begin
            if (mem_ack) begin
              p        <= p + 1'b1;
              dep_pend <= 1'b0;
            end
          end else if (dep) begin
            dep_pend <= 1'b1;
            dep_data <= sw;
          end else if (start) begin
            halt <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (stop) stop_seen <= 1'b1;
          if (mem_ack) begin
            ir     <= mem_rdata[W-1:DEREF];
            p_inst <= p;
            p      <= p + 1'b1;
            ea     <= ea_fetch;
          end
        end
        ST_IND: begin
          if (stop) stop_seen <= 1'b1;
          if (mem_ack) ea <= mem_rdata;
        end
        ST_EXEC: begin
          if (stop) stop_seen <= 1'b1;
          if (retire) begin
            stop_seen <= 1'b0;
            if (halt_set) halt <= 1'b1;
            case (op)
              OP_NOR, OP_ADD, OP_LDA, OP_SHR: begin
                a <= alu_res;
                f <= alu_f;
              end
              OP_JC:   if (f) p <= ea;
              OP_JMP:  p <= ea;
              OP_JZ:   if (a == '0) p <= ea;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign run   = (state != ST_STOP);
  assign a_out = a;
  assign p_out = p;
  assign f_out = f;

endmodule

// File: doc/q2_core_w.md
Q2_CORE_W -- requirements
Module: q2_core_w

Interface
REQ-001 SHALL have parameter W, default 12, meaning data/address word width; legal range 8..16.
REQ-002 SHALL have parameter PAGE_BITS, default W-5, meaning offset field width; fixed at W-5.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 nrst  in  1  asynchronous active-low reset.
REQ-005 start  in  1  level; sampled high in STOP moves the core to FETCH.
REQ-006 stop  in  1  level; requests halt after the current instruction completes.
REQ-007 dep  in  1  single-cycle pulse; front-panel deposit of sw to mem[p], honoured only in STOP.
REQ-008 sw  in  W  front-panel switch data.
REQ-009 mem_req  out  1  memory transaction request, held until ack.
REQ-010 mem_we  out  1  write strobe qualifier, valid while mem_req is high.
REQ-011 mem_addr  out  W  transaction address, stable while mem_req is high.
REQ-012 mem_wdata  out  W  write data, stable while mem_req and mem_we are high.
REQ-013 mem_rdata  in  W  read data, valid in the cycle mem_ack is high.
REQ-014 mem_ack  in  1  completes the transaction in the cycle it is sampled high; any number of wait cycles is allowed.
REQ-015 run  out  1  high in FETCH/IND/EXEC, low in STOP.
REQ-016 halt  out  1  sticky; set on self-jump detection, cleared by start.
REQ-017 a_out, p_out  out  W each  accumulator and program counter, for the panel.
REQ-018 f_out  out  1  flag register.

Function
REQ-019 Instruction fields SHALL be: [W-1:W-3] op, [W-4] deref, [W-5] page, [W-6:0] offset.
REQ-020 Effective address ea SHALL be {p_inst[W-1:W-5], offset} when page=1, and zero-extended offset when page=0; p_inst is the instruction's own address.
REQ-021 States SHALL be STOP, FETCH, IND, EXEC; encodings are defined in the package.
REQ-022 FETCH: read mem[p]; on ack latch ir, p_inst<=p, p<=p+1 mod 2^W; next state IND if deref=1, else EXEC.
REQ-023 IND: read mem[ea]; on ack ea<=mem_rdata; next state EXEC.
REQ-024 Ops: 0 NOR a=~(a|m); 1 ADD a=a+m, f=carry-out; 2 LDA a=m; 3 STA mem[ea]=a; 4 SHR a={f,a[W-1:1]}, f=a[0]; 5 JC p=ea if f; 6 JMP p=ea; 7 JZ p=ea if a==0.
REQ-025 Ops 0-3 SHALL perform one memory access in EXEC and retire on ack; ops 4-7 SHALL retire in one EXEC cycle with mem_req low.
REQ-026 ADD carry SHALL be the W+1 bit of the unsigned sum; NOR, LDA and STA SHALL leave f unchanged.
REQ-027 After retire, next state SHALL be STOP if stop was sampled high at any point since FETCH or halt is set, else FETCH.
REQ-028 halt SHALL set at retire of JMP with deref=0 and ea==p_inst; the core then enters STOP.
REQ-029 In STOP, dep SHALL issue a write of sw to mem[p] and increment p on ack; a second dep during an outstanding deposit SHALL be ignored.
REQ-030 In STOP, start and dep both high SHALL serve dep first; start is re-sampled after the ack.
REQ-031 mem_req SHALL never deassert before ack except on reset; mem_addr, mem_we and mem_wdata SHALL be held constant while it is high.
REQ-032 The reset value of every output SHALL be 0, except mem_addr, which follows p=0.

Reset
REQ-033 nrst low SHALL asynchronously force state=STOP, a=0, p=0, f=0, ir=0, halt=0, and mem_req=0, abandoning any in-flight transaction.
REQ-034 After nrst deasserts, the core SHALL remain in STOP until start is sampled high.

Structure
REQ-035 Package q2_pkg SHALL hold the opcode constants, the state enum and the field-position helpers derived from W.
REQ-036 The word ALU SHALL be a sub-module q2_alu_w (parameter W; inputs op, a, m, f; outputs result, f_next); it is purely combinational.
REQ-037 Target size: 150-300 lines in total.

Verification
REQ-038 W=12, mem[0]=0x405 (LDA 5), mem[5]=0x123, mem[1]=0xC01 (JMP 1), start -> a=0x123, then halt=1 with p_inst=1, run=0.
REQ-039 ADD of 0xFFF+0x001 -> a=0x000, f=1; following SHR -> a=0x800, f=0.
REQ-040 Indirect: mem[0]=0x510 (LDA @0x10), mem[0x10]=0x020, mem[0x20]=0xABC, with mem_ack delayed 3 cycles on each access -> a=0xABC; mem_req is held steady through the waits.
REQ-041 In STOP: dep with sw=0x7FF at p=0xFFF -> mem[0xFFF]=0x7FF and p wraps to 0x000.
REQ-042 nrst pulsed low during the EXEC STA wait -> mem_req drops in the same cycle, memory is not written, and all outputs are 0.
REQ-043 W=8: JZ with a=0 taken and with a=1 not taken; the page bit selects ea correctly.
